// File: rtl/prbs64_pkg.sv
// Shared definitions for the 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60).
// The generator and the checker both import this package, so their stepping stays identical.
package prbs64_pkg;

   localparam int TAP_A = 63;
   localparam int TAP_B = 62;
   localparam int TAP_C = 60;
   localparam int TAP_D = 59;

   localparam logic [63:0] LFSR_ZERO = 64'h0;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } fsm_t;

   function automatic logic [63:0] step(input logic [63:0] s);
      return {s[62:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

endpackage

// File: rtl/prbs64_checker_popcount64.sv
// Combinational 64-bit population count, built as a balanced adder tree.
module popcount64 (
   input  logic [63:0] data,
   output logic [6:0]  count
);

   logic [1:0] l1 [32];
   logic [2:0] l2 [16];
   logic [3:0] l3 [8];
   logic [4:0] l4 [4];
   logic [5:0] l5 [2];

   for (genvar i = 0; i < 32; i++) begin : g_l1
      assign l1[i] = {1'b0, data[2*i]} + {1'b0, data[2*i+1]};
   end
   for (genvar i = 0; i < 16; i++) begin : g_l2
      assign l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
   end
   for (genvar i = 0; i < 8; i++) begin : g_l3
      assign l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
   end
   for (genvar i = 0; i < 4; i++) begin : g_l4
      assign l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
   end
   for (genvar i = 0; i < 2; i++) begin : g_l5
      assign l5[i] = {1'b0, l4[2*i]} + {1'b0, l4[2*i+1]};
   end

   assign count = {1'b0, l5[0]} + {1'b0, l5[1]};

endmodule

// File: rtl/prbs64_checker.sv
// Self-synchronising checker for the 64-bit LFSR state-word stream.
// Seeds from data in HUNT/VERIFY, flywheels in LOCKED, and counts word and bit errors.
module prbs64_checker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             s_rst_n,
   input  logic             in_valid,
   input  logic [63:0]      in_data,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] word_err_cnt,
   output logic [CNT_W-1:0] bit_err_cnt
);
   import prbs64_pkg::*;

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int NW = $clog2(UNLOCK_CNT + 1);
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
   localparam logic [NW-1:0] MISS_LAST  = NW'(UNLOCK_CNT - 1);

   fsm_t          fsm, fsm_nxt;
   logic [63:0]   exp_word;
   logic [MW-1:0] match_cnt;
   logic [NW-1:0] miss_cnt;
   logic          mism, seed_ok, accept_lk, word_err;
   logic [6:0]    pop;
   logic [CNT_W:0] bit_sum;

   assign mism      = (in_data != exp_word);
   assign seed_ok   = (in_data != LFSR_ZERO);
   assign accept_lk = in_valid && (fsm == LOCKED);
   assign word_err  = accept_lk && mism;

   popcount64 u_pop (
      .data  (in_data ^ exp_word),
      .count (pop)
   );

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) fsm <= HUNT;
      else          fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      if (in_valid) begin
         case (fsm)
            HUNT:    if (seed_ok) fsm_nxt = VERIFY;
            VERIFY: begin
               if (!mism) begin
                  if (match_cnt == MATCH_LAST) fsm_nxt = LOCKED;
               end else if (!seed_ok) begin
                  fsm_nxt = HUNT;
               end
            end
            LOCKED:  if (mism && miss_cnt == MISS_LAST) fsm_nxt = HUNT;
            default: fsm_nxt = HUNT;
         endcase
      end
   end

   always_comb begin
      locked = (fsm == LOCKED);
   end

   // In LOCKED the prediction only ever advances from itself, so a corrupted word cannot derail it.
   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         exp_word  <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
      end else if (in_valid) begin
         case (fsm)
            HUNT: begin
               if (seed_ok) begin
                  exp_word  <= step(in_data);
                  match_cnt <= '0;
               end
            end
            VERIFY: begin
               if (!mism) begin
                  exp_word  <= step(exp_word);
                  match_cnt <= match_cnt + 1'b1;
                  if (match_cnt == MATCH_LAST) miss_cnt <= '0;
               end else begin
                  exp_word  <= step(in_data);
                  match_cnt <= '0;
               end
            end
            LOCKED: begin
               exp_word <= step(exp_word);
               miss_cnt <= mism ? miss_cnt + 1'b1 : '0;
            end
            default: ;
         endcase
      end
   end

   assign bit_sum = {1'b0, bit_err_cnt} + (CNT_W + 1)'(pop);

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         word_cnt     <= '0;
         word_err_cnt <= '0;
         bit_err_cnt  <= '0;
      end else if (clr_cnt) begin
         word_cnt     <= '0;
         word_err_cnt <= '0;
         bit_err_cnt  <= '0;
      end else begin
         if (accept_lk && word_cnt != '1)     word_cnt     <= word_cnt + 1'b1;
         if (word_err && word_err_cnt != '1)  word_err_cnt <= word_err_cnt + 1'b1;
         if (word_err) bit_err_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge s_rst_n) begin
      if (!s_rst_n) err_pulse <= 1'b0;
      else          err_pulse <= word_err;
   end

endmodule

// File: tb/tb_prbs64_checker.sv
// Scenario and randomized bench for prbs64_checker against a word-level reference model.
module tb_prbs64_checker;

   localparam int LOCK_CNT   = 4;
   localparam int UNLOCK_CNT = 3;
   localparam int CNT_W      = 32;

   logic             clk = 1'b0;
   logic             s_rst_n;
   logic             in_valid;
   logic [63:0]      in_data;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_err_cnt;
   logic [CNT_W-1:0] bit_err_cnt;

   int total = 0;
   int bad   = 0;

   // reference model: 0 = hunting, 1 = verifying, 2 = locked
   int          m_st;
   logic [63:0] m_exp;
   int          m_match, m_miss;
   logic [31:0] m_wc, m_wec, m_bec;
   bit          m_err;
   logic [63:0] g;

   prbs64_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .s_rst_n      (s_rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .clr_cnt      (clr_cnt),
      .locked       (locked),
      .err_pulse    (err_pulse),
      .word_cnt     (word_cnt),
      .word_err_cnt (word_err_cnt),
      .bit_err_cnt  (bit_err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] nxt(input logic [63:0] s);
      return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_st = 0; m_exp = '0; m_match = 0; m_miss = 0;
      m_wc = 0; m_wec = 0; m_bec = 0; m_err = 0;
   endtask

   task automatic model(input bit v, input logic [63:0] d, input bit c);
      bit mis;
      mis   = (d != m_exp);
      m_err = v && m_st == 2 && mis;
      if (c) begin
         m_wc = 0; m_wec = 0; m_bec = 0;
      end else if (v && m_st == 2) begin
         m_wc++;
         if (mis) begin
            m_wec++;
            m_bec += 32'($countones(d ^ m_exp));
         end
      end
      if (v) begin
         case (m_st)
            0: if (d != 0) begin m_exp = nxt(d); m_match = 0; m_st = 1; end
            1: begin
               if (!mis) begin
                  m_exp = nxt(m_exp); m_match++;
                  if (m_match == LOCK_CNT) begin m_st = 2; m_miss = 0; end
               end else begin
                  m_exp = nxt(d); m_match = 0;
                  if (d == 0) m_st = 0;
               end
            end
            default: begin
               m_exp = nxt(m_exp);
               if (!mis) m_miss = 0;
               else begin
                  m_miss++;
                  if (m_miss == UNLOCK_CNT) m_st = 0;
               end
            end
         endcase
      end
   endtask

   task automatic tick(input bit v, input logic [63:0] d, input bit c);
      in_valid = v; in_data = d; clr_cnt = c;
      @(posedge clk);
      model(v, d, c);
      #1;
   endtask

   task automatic send_good();
      tick(1'b1, g, 1'b0);
      g = nxt(g);
   endtask

   task automatic do_reset();
      in_valid = 0; in_data = '0; clr_cnt = 0;
      s_rst_n = 0;
      model_reset();
      #3;
      s_rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 0; in_data = '0; clr_cnt = 0;
      s_rst_n = 0;
      model_reset();
      #12;
      total += 5;
      if (locked !== 1'b0)     begin bad++; $display("FAIL reset_locked got %0h want 0", locked); end
      if (err_pulse !== 1'b0)  begin bad++; $display("FAIL reset_err_pulse got %0h want 0", err_pulse); end
      if (word_cnt !== 0)      begin bad++; $display("FAIL reset_word_cnt got %0h want 0", word_cnt); end
      if (word_err_cnt !== 0)  begin bad++; $display("FAIL reset_word_err got %0h want 0", word_err_cnt); end
      if (bit_err_cnt !== 0)   begin bad++; $display("FAIL reset_bit_err got %0h want 0", bit_err_cnt); end
      s_rst_n = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_lock();
      tick(1'b1, 64'hFEDCBA9876543210, 1'b0);
      tick(1'b1, 64'hFDB97530ECA86420, 1'b0);
      g = nxt(64'hFDB97530ECA86420);
      send_good();
      send_good();
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got %0h want 0", locked); end
      send_good();
      total += 4;
      if (locked !== 1'b1)    begin bad++; $display("FAIL lock_rise got %0h want 1", locked); end
      if (word_cnt !== 0)     begin bad++; $display("FAIL lock_word_cnt got %0h want 0", word_cnt); end
      if (word_err_cnt !== 0) begin bad++; $display("FAIL lock_word_err got %0h want 0", word_err_cnt); end
      if (err_pulse !== 0)    begin bad++; $display("FAIL lock_err_pulse got %0h want 0", err_pulse); end
      send_good();
      total++;
      if (word_cnt !== 1) begin bad++; $display("FAIL lock_first_count got %0h want 1", word_cnt); end
   endtask

   task automatic test_single_err();
      send_good();
      tick(1'b1, g ^ 64'h1, 1'b0);
      g = nxt(g);
      total += 5;
      if (err_pulse !== 1'b1) begin bad++; $display("FAIL single_pulse got %0h want 1", err_pulse); end
      if (word_err_cnt !== 1) begin bad++; $display("FAIL single_word_err got %0h want 1", word_err_cnt); end
      if (bit_err_cnt !== 1)  begin bad++; $display("FAIL single_bit_err got %0h want 1", bit_err_cnt); end
      if (locked !== 1'b1)    begin bad++; $display("FAIL single_locked got %0h want 1", locked); end
      if (word_cnt !== 3)     begin bad++; $display("FAIL single_word_cnt got %0h want 3", word_cnt); end
      send_good();
      total += 3;
      if (err_pulse !== 1'b0) begin bad++; $display("FAIL single_pulse_end got %0h want 0", err_pulse); end
      if (locked !== 1'b1)    begin bad++; $display("FAIL single_still_locked got %0h want 1", locked); end
      if (word_err_cnt !== 1) begin bad++; $display("FAIL single_no_more_err got %0h want 1", word_err_cnt); end
      send_good();
   endtask

   task automatic test_burst_loss();
      tick(1'b0, rnd64(), 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, g ^ 64'hFF, 1'b0);
         g = nxt(g);
         total++;
         if (locked !== (k < 2)) begin bad++; $display("FAIL burst_locked_%0d got %0h want %0h", k, locked, k < 2); end
      end
      total += 4;
      if (word_err_cnt !== 3) begin bad++; $display("FAIL burst_word_err got %0h want 3", word_err_cnt); end
      if (bit_err_cnt !== 24) begin bad++; $display("FAIL burst_bit_err got %0h want 24", bit_err_cnt); end
      if (word_cnt !== 3)     begin bad++; $display("FAIL burst_word_cnt got %0h want 3", word_cnt); end
      if (err_pulse !== 1'b1) begin bad++; $display("FAIL burst_pulse got %0h want 1", err_pulse); end
      send_good();
      send_good();
      total += 2;
      if (locked !== 1'b0) begin bad++; $display("FAIL burst_hunt got %0h want 0", locked); end
      if (word_cnt !== 3)  begin bad++; $display("FAIL burst_no_count got %0h want 3", word_cnt); end
   endtask

   task automatic test_zero_lockup();
      do_reset();
      for (int k = 0; k < 6; k++) tick(1'b1, 64'h0, 1'b0);
      total += 3;
      if (locked !== 1'b0)                      begin bad++; $display("FAIL zero_locked got %0h want 0", locked); end
      if ({word_cnt, word_err_cnt} !== '0)      begin bad++; $display("FAIL zero_counts got %0h want 0", {word_cnt, word_err_cnt}); end
      if (err_pulse !== 1'b0)                   begin bad++; $display("FAIL zero_pulse got %0h want 0", err_pulse); end
      // a fresh seed plus LOCK_CNT matches must lock, proving zeros left nothing behind
      g = 64'h0123456789ABCDEF;
      for (int k = 0; k < LOCK_CNT + 1; k++) send_good();
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL zero_relock got %0h want 1", locked); end
   endtask

   task automatic test_gaps_verify_mismatch();
      logic [63:0] w;
      do_reset();
      g = rnd64() | 64'h1;
      for (int k = 0; k < 3; k++) begin
         repeat ($urandom_range(0, 2)) tick(1'b0, rnd64(), 1'b0);
         send_good();
      end
      w = g ^ (64'h1 << $urandom_range(0, 63));
      if (w == 0) w = 64'h5;
      tick(1'b1, w, 1'b0);
      g = nxt(w);
      for (int k = 0; k < LOCK_CNT; k++) begin
         repeat ($urandom_range(1, 3)) tick(1'b0, rnd64(), 1'b0);
         total++;
         if (locked !== 1'b0) begin bad++; $display("FAIL gap_premature_%0d got %0h want 0", k, locked); end
         send_good();
      end
      total += 2;
      if (locked !== 1'b1)  begin bad++; $display("FAIL gap_lock got %0h want 1", locked); end
      if (word_cnt !== 0)   begin bad++; $display("FAIL gap_word_cnt got %0h want 0", word_cnt); end
      tick(1'b0, rnd64(), 1'b0);
      total++;
      if (locked !== 1'b1)  begin bad++; $display("FAIL gap_hold got %0h want 1", locked); end
   endtask

   task automatic test_clr_coincident();
      send_good();
      tick(1'b1, g ^ 64'h3, 1'b1);
      g = nxt(g);
      total += 5;
      if (word_cnt !== 0)     begin bad++; $display("FAIL clr_word_cnt got %0h want 0", word_cnt); end
      if (word_err_cnt !== 0) begin bad++; $display("FAIL clr_word_err got %0h want 0", word_err_cnt); end
      if (bit_err_cnt !== 0)  begin bad++; $display("FAIL clr_bit_err got %0h want 0", bit_err_cnt); end
      if (err_pulse !== 1'b1) begin bad++; $display("FAIL clr_pulse got %0h want 1", err_pulse); end
      if (locked !== 1'b1)    begin bad++; $display("FAIL clr_locked got %0h want 1", locked); end
   endtask

   task automatic test_async_reset();
      tick(1'b1, g ^ 64'hF0, 1'b0);
      g = nxt(g);
      in_valid = 0;
      #1;
      s_rst_n = 0;
      model_reset();
      #1;
      total += 3;
      if (locked !== 1'b0)    begin bad++; $display("FAIL arst_locked got %0h want 0", locked); end
      if (err_pulse !== 1'b0) begin bad++; $display("FAIL arst_pulse got %0h want 0", err_pulse); end
      if ({word_cnt, word_err_cnt, bit_err_cnt} !== '0) begin
         bad++; $display("FAIL arst_counts got %0h want 0", {word_cnt, word_err_cnt, bit_err_cnt});
      end
      s_rst_n = 1;
      tick(1'b0, 64'h0, 1'b0);
      for (int k = 0; k < LOCK_CNT; k++) send_good();
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL arst_relock_early got %0h want 0", locked); end
      send_good();
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL arst_relock got %0h want 1", locked); end
   endtask

   task automatic test_random();
      logic [63:0] d;
      bit v, c;
      do_reset();
      g = rnd64() | 64'h8000;
      for (int n = 0; n < 600; n++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 40) == 0);
         d = v ? g : rnd64();
         if (v && $urandom_range(0, 11) == 0) d ^= rnd64() & {$urandom_range(1, 255)};
         if (v && $urandom_range(0, 199) == 0) d = 64'h0;
         if (v && $urandom_range(0, 149) == 0) g = rnd64() | 64'h1;
         tick(v, d, c);
         if (v) g = nxt(g);
         total += 3;
         if (locked !== (m_st == 2)) begin bad++; $display("FAIL rnd_locked n=%0d got %0h want %0h", n, locked, m_st == 2); end
         if (err_pulse !== m_err)    begin bad++; $display("FAIL rnd_pulse n=%0d got %0h want %0h", n, err_pulse, m_err); end
         if ({word_cnt, word_err_cnt, bit_err_cnt} !== {m_wc, m_wec, m_bec}) begin
            bad++;
            $display("FAIL rnd_counts n=%0d got %0h/%0h/%0h want %0h/%0h/%0h",
                     n, word_cnt, word_err_cnt, bit_err_cnt, m_wc, m_wec, m_bec);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_single_err();
      test_burst_loss();
      test_zero_lockup();
      test_gaps_verify_mismatch();
      test_clr_coincident();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
